// File: rtl/stress_response.sv
`default_nettype none
// ============================================================================
// Module      : stress_response
// Description : Four-state stress-response controller driven by a downscaled
//               cortisol level. State moves one step at a time after a run of
//               consecutive qualifying ticks. A long run at the maximum level
//               in STRESSED forces EXHAUSTED. A long run at level 0 in
//               EXHAUSTED returns directly to CALM.
//
// Ports       : clk            - system clock, rising-edge active
//               rst_n          - synchronous active-low reset
//               cortisol_level - input level 0..3
//               tick           - evaluation strobe; nothing advances without it
//               stress_state   - 0 CALM, 1 ALERT, 2 STRESSED, 3 EXHAUSTED
//               state_change   - one-cycle pulse when stress_state changes
//               exhaust_count  - saturating count of entries into EXHAUSTED
// Revision    : 1.0 - initial release
// ============================================================================
module stress_response #(
    parameter int unsigned DWELL         = 4,
    parameter int unsigned RECOVER       = 8,
    parameter int unsigned EXHAUST_LIMIT = 16,
    parameter int unsigned EXHAUST_REST  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] cortisol_level,
    input  logic       tick,
    output logic [1:0] stress_state,
    output logic       state_change,
    output logic [3:0] exhaust_count
);

    localparam logic [7:0] c_dwell   = DWELL[7:0];
    localparam logic [7:0] c_recover = RECOVER[7:0];
    localparam logic [7:0] c_limit   = EXHAUST_LIMIT[7:0];
    localparam logic [7:0] c_rest    = EXHAUST_REST[7:0];

    typedef enum logic [1:0] {
        ST_CALM      = 2'd0,
        ST_ALERT     = 2'd1,
        ST_STRESSED  = 2'd2,
        ST_EXHAUSTED = 2'd3
    } state_t;

    state_t     r_state,  w_state_nxt;
    logic [7:0] r_esc,    w_esc_nxt;
    logic [7:0] r_rec,    w_rec_nxt;
    logic [7:0] r_exh,    w_exh_nxt;
    logic [7:0] r_rest,   w_rest_nxt;
    logic [3:0] r_cnt,    w_cnt_nxt;
    logic       r_change, w_change_nxt;

    logic [1:0] w_target;
    logic [7:0] w_esc_inc;
    logic [7:0] w_rec_inc;
    logic [7:0] w_exh_inc;
    logic [7:0] w_rest_inc;
    logic       w_level_max;

    // Target level clamps at STRESSED; EXHAUSTED is reachable only through
    // the exhaust timer, never by ordinary escalation.
    assign w_target    = (cortisol_level == 2'd3) ? 2'd2 : cortisol_level;
    assign w_level_max = (cortisol_level == 2'd3);
    assign w_esc_inc   = r_esc + 8'd1;
    assign w_rec_inc   = r_rec + 8'd1;
    assign w_exh_inc   = r_exh + 8'd1;
    assign w_rest_inc  = r_rest + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_CALM;
            r_esc    <= 8'd0;
            r_rec    <= 8'd0;
            r_exh    <= 8'd0;
            r_rest   <= 8'd0;
            r_cnt    <= 4'd0;
            r_change <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_esc    <= w_esc_nxt;
            r_rec    <= w_rec_nxt;
            r_exh    <= w_exh_nxt;
            r_rest   <= w_rest_nxt;
            r_cnt    <= w_cnt_nxt;
            r_change <= w_change_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_esc_nxt    = r_esc;
        w_rec_nxt    = r_rec;
        w_exh_nxt    = r_exh;
        w_rest_nxt   = r_rest;
        w_cnt_nxt    = r_cnt;
        w_change_nxt = 1'b0;

        if (tick) begin
            if (r_state == ST_EXHAUSTED) begin
                w_esc_nxt = 8'd0;
                w_rec_nxt = 8'd0;
                w_exh_nxt = 8'd0;
                if (cortisol_level == 2'd0) begin
                    if (w_rest_inc == c_rest) begin
                        w_state_nxt  = ST_CALM;
                        w_rest_nxt   = 8'd0;
                        w_change_nxt = 1'b1;
                    end else begin
                        w_rest_nxt = w_rest_inc;
                    end
                end else begin
                    w_rest_nxt = 8'd0;
                end
            end else begin
                w_rest_nxt = 8'd0;
                w_esc_nxt  = (w_target > r_state) ? w_esc_inc : 8'd0;
                w_rec_nxt  = (w_target < r_state) ? w_rec_inc : 8'd0;
                w_exh_nxt  = ((r_state == ST_STRESSED) && w_level_max) ? w_exh_inc : 8'd0;

                // Exhaustion requires level 3 while recovery requires level < 2,
                // so at most one of these branches can qualify on a given tick.
                if ((r_state == ST_STRESSED) && w_level_max && (w_exh_inc == c_limit)) begin
                    w_state_nxt  = ST_EXHAUSTED;
                    w_cnt_nxt    = (r_cnt == 4'd15) ? r_cnt : r_cnt + 4'd1;
                    w_esc_nxt    = 8'd0;
                    w_rec_nxt    = 8'd0;
                    w_exh_nxt    = 8'd0;
                    w_change_nxt = 1'b1;
                end else if ((w_target > r_state) && (w_esc_inc == c_dwell)) begin
                    w_state_nxt  = state_t'(r_state + 2'd1);
                    w_esc_nxt    = 8'd0;
                    w_rec_nxt    = 8'd0;
                    w_change_nxt = 1'b1;
                end else if ((w_target < r_state) && (w_rec_inc == c_recover)) begin
                    w_state_nxt  = state_t'(r_state - 2'd1);
                    w_esc_nxt    = 8'd0;
                    w_rec_nxt    = 8'd0;
                    w_exh_nxt    = 8'd0;
                    w_change_nxt = 1'b1;
                end
            end
        end
    end

    assign stress_state  = r_state;
    assign state_change  = r_change;
    assign exhaust_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_stress_response.sv
`default_nettype none
// ============================================================================
// Module      : tb_stress_response
// Description : Self-checking bench for stress_response. A driver issues one
//               stimulus cycle at a time and pushes the reference model's
//               expected outputs into a queue; a monitor pops one entry per
//               clock and compares it with the DUT outputs. Directed scenarios
//               add fixed-value checks, followed by a randomized soak.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stress_response;

    localparam int DWELL         = 4;
    localparam int RECOVER       = 8;
    localparam int EXHAUST_LIMIT = 16;
    localparam int EXHAUST_REST  = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] cortisol_level = 2'd0;
    logic       tick = 1'b0;
    logic [1:0] stress_state;
    logic       state_change;
    logic [3:0] exhaust_count;

    stress_response #(
        .DWELL        (DWELL),
        .RECOVER      (RECOVER),
        .EXHAUST_LIMIT(EXHAUST_LIMIT),
        .EXHAUST_REST (EXHAUST_REST)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cortisol_level(cortisol_level),
        .tick          (tick),
        .stress_state  (stress_state),
        .state_change  (state_change),
        .exhaust_count (exhaust_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int state;
        int change;
        int count;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: behavioural rules with plain integers.
    int m_state = 0, m_cnt = 0;
    int m_up = 0, m_down = 0, m_exh = 0, m_rest = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_step(input bit rn, input int lvl, input bit tk);
        exp_t e;
        int   tgt;
        e.change = 0;
        if (!rn) begin
            m_state = 0; m_cnt = 0; m_up = 0; m_down = 0; m_exh = 0; m_rest = 0;
        end else if (tk) begin
            tgt = (lvl > 2) ? 2 : lvl;
            if (m_state == 3) begin
                m_rest = (lvl == 0) ? m_rest + 1 : 0;
                if (m_rest == EXHAUST_REST) begin
                    m_state = 0; m_rest = 0; e.change = 1;
                end
            end else begin
                m_up   = (tgt > m_state) ? m_up + 1 : 0;
                m_down = (tgt < m_state) ? m_down + 1 : 0;
                m_exh  = (m_state == 2 && lvl == 3) ? m_exh + 1 : 0;
                if (m_exh == EXHAUST_LIMIT) begin
                    m_state = 3;
                    if (m_cnt < 15) m_cnt++;
                    m_up = 0; m_down = 0; m_exh = 0; e.change = 1;
                end else if (m_up == DWELL) begin
                    m_state++; m_up = 0; m_down = 0; e.change = 1;
                end else if (m_down == RECOVER) begin
                    m_state--; m_up = 0; m_down = 0; m_exh = 0; e.change = 1;
                end
            end
        end
        e.state = m_state;
        e.count = m_cnt;
        return e;
    endfunction

    // Drive one cycle of stimulus and queue the outputs expected after the edge.
    task automatic step(input bit rn, input int lvl, input bit tk);
        @(negedge clk);
        rst_n          = rn;
        cortisol_level = 2'(lvl);
        tick           = tk;
        exp_q.push_back(model_step(rn, lvl, tk));
    endtask

    task automatic ticks(input int n, input int lvl);
        for (int i = 0; i < n; i++) step(1'b1, lvl, 1'b1);
    endtask

    // Sample outputs of the most recent step, away from the active edge.
    task automatic check_now(input string name, input int st, input int cnt);
        @(posedge clk);
        #2;
        check({name, "_state"}, int'(stress_state), st);
        check({name, "_count"}, int'(exhaust_count), cnt);
    endtask

    // Monitor: one expected entry per clock edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_state",  int'(stress_state),  e.state);
            check("sb_change", int'(state_change),  e.change);
            check("sb_count",  int'(exhaust_count), e.count);
        end
    end

    initial begin
        int mode;
        // Reset
        step(1'b0, 0, 1'b1);
        step(1'b0, 3, 1'b1);
        check_now("reset", 0, 0);

        // Level 1 held: ALERT after 4th tick, then stays.
        ticks(3, 1);
        check_now("esc_pre", 0, 0);
        ticks(1, 1);
        check_now("esc_4th", 1, 0);
        ticks(10, 1);
        check_now("alert_hold", 1, 0);

        // Level 3 from CALM: ALERT@4, STRESSED@8, EXHAUSTED@24.
        step(1'b0, 0, 1'b0);
        ticks(8, 3);
        check_now("lvl3_8", 2, 0);
        ticks(15, 3);
        check_now("lvl3_23", 2, 0);
        ticks(1, 3);
        check_now("lvl3_24", 3, 1);

        // Rest run broken by one non-zero tick.
        ticks(31, 0);
        ticks(1, 1);
        ticks(31, 0);
        check_now("rest_31", 3, 1);
        ticks(1, 0);
        check_now("rest_32", 0, 1);

        // Recovery interrupted: no skip to CALM.
        step(1'b0, 0, 1'b0);
        ticks(8, 2);
        check_now("to_stressed", 2, 0);
        ticks(7, 0);
        ticks(1, 2);
        ticks(7, 0);
        check_now("rec_7", 2, 0);
        ticks(1, 0);
        check_now("rec_8", 1, 0);

        // Escalation paused by tick=0.
        step(1'b0, 0, 1'b0);
        ticks(3, 1);
        for (int i = 0; i < 10; i++) step(1'b1, 1, 1'b0);
        check_now("pause", 0, 0);
        ticks(1, 1);
        check_now("resume", 1, 0);

        // Exhaustion counter saturation.
        step(1'b0, 0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            ticks(EXHAUST_LIMIT + 2 * DWELL, 3);
            ticks(EXHAUST_REST, 0);
        end
        check_now("saturate", 0, 15);

        // Reset mid-dwell discards progress.
        ticks(3, 1);
        step(1'b0, 1, 1'b1);
        check_now("rst_mid", 0, 0);
        ticks(3, 1);
        check_now("post_rst_3", 0, 0);
        ticks(1, 1);
        check_now("post_rst_4", 1, 0);

        // Randomized soak with level runs long enough to reach exhaustion.
        mode = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) mode = $urandom_range(0, 4);
            step(($urandom_range(0, 799) != 0),
                 (mode == 4) ? $urandom_range(0, 3) : mode,
                 ($urandom_range(0, 3) != 0));
        end

        @(posedge clk);
        #3;
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
